noc_perf_monitor: RTL and testbench
===================================

NOC_PERF_MONITOR -- requirements
Module: noc_perf_monitor

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of NoC output ports monitored.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload bits per flit.
REQ-003 SHALL have parameter ADDR_WIDTH, default 2: destination-address bits per flit; TW = DATA_WIDTH+ADDR_WIDTH.
REQ-004 SHALL have parameter CNT_WIDTH, default 32: width of all counters and timestamps.
REQ-005 SHALL have parameter EXPECTED_PKTS, default 400: accepted-flit total that ends a run.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 100000: maximum RUN duration in cycles.
REQ-007 SHALL have ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- i_start  in  1  begin measurement (IDLE only)
- i_clear  in  1  abort and clear to IDLE
- i_mon_data  in  NUM_PORTS*TW  flit per port; port p at [p*TW +: TW]; address = top ADDR_WIDTH bits of each slice
- i_mon_valid  in  NUM_PORTS  per-port valid
- i_mon_ready  in  NUM_PORTS  per-port ready
- i_sel  in  ADDR_WIDTH  port selector for o_port_pkts
- o_state  out  2  00 IDLE, 01 RUN, 10 DONE, 11 TIMEOUT
- o_done  out  1  high in DONE
- o_timeout  out  1  high in TIMEOUT
- o_total_pkts  out  CNT_WIDTH  accepted flits this run
- o_port_pkts  out  CNT_WIDTH  accepted flits on port i_sel
- o_misroute_cnt  out  CNT_WIDTH  accepted flits whose address != port index
- o_start_cycle  out  CNT_WIDTH  cycle stamp at RUN entry
- o_stop_cycle  out  CNT_WIDTH  cycle stamp at DONE/TIMEOUT entry
- o_elapsed  out  CNT_WIDTH  o_stop_cycle - o_start_cycle, modulo 2^CNT_WIDTH

Function
REQ-008 SHALL count a flit on port p as accepted only when i_mon_valid[p] & i_mon_ready[p] at a rising edge.
REQ-009 SHALL maintain a free-running cycle counter, 0 after reset, +1 per cycle, wrapping at 2^CNT_WIDTH.
REQ-010 IDLE: accepted flits ignored; i_start=1 -> RUN next cycle; o_start_cycle latches the cycle counter value of that edge.
REQ-011 RUN: per cycle, o_total_pkts += popcount of accepted flits across all ports; per-port counters += 1 per accepted flit; o_misroute_cnt += number of accepted flits with address != p.
REQ-012 RUN -> DONE on the edge where the updated total >= EXPECTED_PKTS; that cycle's flits are counted, so total may exceed EXPECTED_PKTS by up to NUM_PORTS-1.
REQ-013 RUN -> TIMEOUT on the edge where the RUN cycle count reaches TIMEOUT_CYCLES without DONE; DONE wins if both occur on the same edge.
REQ-014 On DONE or TIMEOUT entry, o_stop_cycle SHALL latch the cycle counter; o_elapsed is combinational from the two stamps.
REQ-015 DONE and TIMEOUT: all counters and stamps frozen; i_start ignored; exit only via i_clear or rst.
REQ-016 i_clear=1 in any state -> IDLE next cycle, all run counters and stamps zeroed; the free-running counter is not cleared; i_clear has priority over i_start and all transitions.
REQ-017 All counters SHALL saturate at 2^CNT_WIDTH-1, never wrap (except REQ-009).
REQ-018 o_port_pkts SHALL be combinational from i_sel; i_sel >= NUM_PORTS yields 0.
REQ-019 o_done/o_timeout SHALL be registered, decoded directly from state, with no extra latency.

Reset
REQ-020 rst=1 at a rising edge SHALL force IDLE and zero all outputs and counters, including the free-running counter, overriding i_clear and i_start.
REQ-021 rst asserted mid-RUN SHALL discard that cycle's accepted flits.

Verification (NUM_PORTS=4, EXPECTED_PKTS=8, TIMEOUT_CYCLES=50, CNT_WIDTH=16)
REQ-022 Release rst; at cycle 5 pulse i_start; valid=ready=4'b1111 with correct addresses for 2 cycles -> DONE after the 2nd cycle, total=8, each port=2, misroute=0, start=5, elapsed=2.
REQ-023 valid=4'b1111 with ready=4'b0101 -> only ports 0 and 2 count, +2 per cycle; at 3 ports/cycle, total=9 at DONE.
REQ-024 Port 1 carries address 3, 4 flits accepted -> misroute=4, port 1 count=4.
REQ-025 RUN with no traffic -> TIMEOUT exactly 50 cycles after RUN entry, elapsed=50; 8th flit on the timeout edge -> DONE, not TIMEOUT.
REQ-026 i_clear in DONE -> IDLE, counters zero; a new i_start run measures correctly; rst mid-RUN -> IDLE, zeros.
REQ-027 Flits while IDLE, including on the i_start edge, -> total stays 0.

Source files
------------

// File: rtl/noc_perf_monitor.sv
// noc_perf_monitor: counts accepted NoC flits per run, flags misroutes, stamps run start/stop cycles
// Ports: clk/rst (sync, active-high); i_start begins a run from IDLE; i_clear aborts to IDLE;
//        i_mon_data/i_mon_valid/i_mon_ready carry one flit per port (address in top ADDR_WIDTH bits);
//        i_sel picks the port shown on o_port_pkts; o_state/o_done/o_timeout report the run state;
//        o_total_pkts, o_misroute_cnt, o_start_cycle, o_stop_cycle, o_elapsed are run statistics.
module noc_perf_monitor #(
   parameter int NUM_PORTS      = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 2,
   parameter int CNT_WIDTH      = 32,
   parameter int EXPECTED_PKTS  = 400,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        i_start,
   input  logic                                        i_clear,
   input  logic [NUM_PORTS*(DATA_WIDTH+ADDR_WIDTH)-1:0] i_mon_data,
   input  logic [NUM_PORTS-1:0]                        i_mon_valid,
   input  logic [NUM_PORTS-1:0]                        i_mon_ready,
   input  logic [ADDR_WIDTH-1:0]                       i_sel,
   output logic [1:0]                                  o_state,
   output logic                                        o_done,
   output logic                                        o_timeout,
   output logic [CNT_WIDTH-1:0]                        o_total_pkts,
   output logic [CNT_WIDTH-1:0]                        o_port_pkts,
   output logic [CNT_WIDTH-1:0]                        o_misroute_cnt,
   output logic [CNT_WIDTH-1:0]                        o_start_cycle,
   output logic [CNT_WIDTH-1:0]                        o_stop_cycle,
   output logic [CNT_WIDTH-1:0]                        o_elapsed
);
   localparam int TW = DATA_WIDTH + ADDR_WIDTH;
   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] EXP = CNT_WIDTH'(EXPECTED_PKTS);
   localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [CNT_WIDTH:0] MAXV = {1'b0, {CNT_WIDTH{1'b1}}};
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10, TOUT = 2'b11} state_t;
   state_t state, state_d;
   logic [CNT_WIDTH-1:0] cyc, run_cyc, total, misroute, start_cyc, stop_cyc;
   logic [CNT_WIDTH-1:0] port_cnt [NUM_PORTS];
   logic [NUM_PORTS-1:0] acc;
   logic [CNT_WIDTH:0] acc_n, mis_n, total_sum, mis_sum, run_sum;
   logic [CNT_WIDTH-1:0] total_nxt, mis_nxt, run_nxt;
   always_comb begin
      acc = '0;
      acc_n = '0;
      mis_n = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         acc[p] = i_mon_valid[p] & i_mon_ready[p];
         acc_n = acc_n + (CNT_WIDTH+1)'(acc[p]);
         mis_n = mis_n + (CNT_WIDTH+1)'(acc[p] && int'(i_mon_data[p*TW+DATA_WIDTH +: ADDR_WIDTH]) != p);
      end
      // one extra bit catches overflow so the counters saturate instead of wrapping
      total_sum = {1'b0, total} + acc_n;
      mis_sum = {1'b0, misroute} + mis_n;
      run_sum = {1'b0, run_cyc} + (CNT_WIDTH+1)'(1);
      total_nxt = total_sum > MAXV ? '1 : total_sum[CNT_WIDTH-1:0];
      mis_nxt = mis_sum > MAXV ? '1 : mis_sum[CNT_WIDTH-1:0];
      run_nxt = run_sum > MAXV ? '1 : run_sum[CNT_WIDTH-1:0];
   end
   // DONE is tested before TIMEOUT so a run that completes on the timeout edge reports DONE
   always_comb begin
      state_d = state;
      state_d = i_clear ? IDLE :
                (state == IDLE && i_start) ? RUN :
                (state == RUN && total_nxt >= EXP) ? DONE :
                (state == RUN && run_nxt >= TMO) ? TOUT : state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cyc <= '0;
         run_cyc <= '0;
         total <= '0;
         misroute <= '0;
         start_cyc <= '0;
         stop_cyc <= '0;
         for (int p = 0; p < NUM_PORTS; p++) port_cnt[p] <= '0;
      end else begin
         state <= state_d;
         cyc <= cyc + ONE;
         if (i_clear) begin
            run_cyc <= '0;
            total <= '0;
            misroute <= '0;
            start_cyc <= '0;
            stop_cyc <= '0;
            for (int p = 0; p < NUM_PORTS; p++) port_cnt[p] <= '0;
         end else if (state == IDLE && i_start) begin
            start_cyc <= cyc;
            run_cyc <= '0;
         end else if (state == RUN) begin
            total <= total_nxt;
            misroute <= mis_nxt;
            run_cyc <= run_nxt;
            for (int p = 0; p < NUM_PORTS; p++)
               if (acc[p] && port_cnt[p] != '1) port_cnt[p] <= port_cnt[p] + ONE;
            if (state_d != RUN) stop_cyc <= cyc;
         end
      end
   end
   assign o_state = state;
   assign o_done = state == DONE;
   assign o_timeout = state == TOUT;
   assign o_total_pkts = total;
   assign o_misroute_cnt = misroute;
   assign o_start_cycle = start_cyc;
   assign o_stop_cycle = stop_cyc;
   assign o_elapsed = stop_cyc - start_cyc;
   assign o_port_pkts = int'(i_sel) < NUM_PORTS ? port_cnt[i_sel] : '0;
endmodule

// File: tb/tb_noc_perf_monitor.sv
// tb_noc_perf_monitor: directed stimulus with a cycle-level reference model and literal spot checks
module tb_noc_perf_monitor;
   localparam int NP = 4, DW = 32, AW = 2, CW = 16, EXP = 8, TMO = 50;
   localparam int TW = DW + AW;
   logic clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_clear = 1'b0;
   logic [NP*TW-1:0] i_mon_data = '0;
   logic [NP-1:0] i_mon_valid = '0, i_mon_ready = '0;
   logic [AW-1:0] i_sel = '0;
   logic [1:0] o_state;
   logic o_done, o_timeout;
   logic [CW-1:0] o_total_pkts, o_port_pkts, o_misroute_cnt, o_start_cycle, o_stop_cycle, o_elapsed;
   int vectors = 0, miscompares = 0;
   bit armed = 0;
   int ms, mcyc, mtot, mmis, mstart, mstop, mrun;
   int mport [NP];

   noc_perf_monitor #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW),
                      .EXPECTED_PKTS(EXP), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_clear(i_clear), .i_mon_data(i_mon_data),
      .i_mon_valid(i_mon_valid), .i_mon_ready(i_mon_ready), .i_sel(i_sel), .o_state(o_state),
      .o_done(o_done), .o_timeout(o_timeout), .o_total_pkts(o_total_pkts), .o_port_pkts(o_port_pkts),
      .o_misroute_cnt(o_misroute_cnt), .o_start_cycle(o_start_cycle), .o_stop_cycle(o_stop_cycle),
      .o_elapsed(o_elapsed));

   always #5 clk = ~clk;

   function automatic int sat(input int v);
      return v > 65535 ? 65535 : v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference: run rules expressed on plain integers
   always @(posedge clk) begin
      int n, m;
      n = 0;
      m = 0;
      for (int p = 0; p < NP; p++)
         if (i_mon_valid[p] && i_mon_ready[p]) begin
            n++;
            if (int'(i_mon_data[p*TW+DW +: AW]) != p) m++;
         end
      if (rst) begin
         ms = 0; mcyc = 0; mtot = 0; mmis = 0; mstart = 0; mstop = 0; mrun = 0;
         for (int p = 0; p < NP; p++) mport[p] = 0;
      end else begin
         if (i_clear) begin
            ms = 0; mtot = 0; mmis = 0; mstart = 0; mstop = 0; mrun = 0;
            for (int p = 0; p < NP; p++) mport[p] = 0;
         end else if (ms == 0 && i_start) begin
            ms = 1; mstart = mcyc; mrun = 0;
         end else if (ms == 1) begin
            mtot = sat(mtot + n);
            mmis = sat(mmis + m);
            for (int p = 0; p < NP; p++)
               if (i_mon_valid[p] && i_mon_ready[p]) mport[p] = sat(mport[p] + 1);
            mrun++;
            if (mtot >= EXP) begin ms = 2; mstop = mcyc; end
            else if (mrun >= TMO) begin ms = 3; mstop = mcyc; end
         end
         mcyc = (mcyc + 1) % 65536;
      end
   end

   always @(negedge clk) if (armed) begin
      chk("state", int'(o_state), ms);
      chk("done", int'(o_done), int'(ms == 2));
      chk("timeout", int'(o_timeout), int'(ms == 3));
      chk("total", int'(o_total_pkts), mtot);
      chk("port_pkts", int'(o_port_pkts), mport[int'(i_sel)]);
      chk("misroute", int'(o_misroute_cnt), mmis);
      chk("start_cycle", int'(o_start_cycle), mstart);
      chk("stop_cycle", int'(o_stop_cycle), mstop);
      chk("elapsed", int'(o_elapsed), ((mstop - mstart) % 65536 + 65536) % 65536);
   end

   task automatic tick(input int k = 1);
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic flits(input logic [3:0] v, input logic [3:0] r, input logic [7:0] a);
      for (int p = 0; p < NP; p++) i_mon_data[p*TW +: TW] = {a[p*2 +: 2], DW'($urandom)};
      i_mon_valid = v;
      i_mon_ready = r;
   endtask

   task automatic port_is(input int p, input int exp);
      i_sel = AW'(p);
      #1;
      chk("port_lit", int'(o_port_pkts), exp);
   endtask

   initial begin
      tick(2);
      armed = 1;
      chk("rst_state", int'(o_state), 0);
      chk("rst_total", int'(o_total_pkts), 0);
      rst = 1'b0;
      // idle traffic, including the start edge, must not count
      flits(4'hF, 4'hF, 8'hE4);
      tick(5);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("run_entry", int'(o_state), 1);
      chk("idle_total", int'(o_total_pkts), 0);
      tick(2);
      chk("s1_state", int'(o_state), 2);
      chk("s1_done", int'(o_done), 1);
      chk("s1_total", int'(o_total_pkts), 8);
      chk("s1_start", int'(o_start_cycle), 5);
      chk("s1_stop", int'(o_stop_cycle), 7);
      chk("s1_elapsed", int'(o_elapsed), 2);
      chk("s1_mis", int'(o_misroute_cnt), 0);
      for (int p = 0; p < NP; p++) port_is(p, 2);
      i_start = 1'b1;
      tick(3);
      i_start = 1'b0;
      chk("frozen_total", int'(o_total_pkts), 8);
      chk("frozen_state", int'(o_state), 2);
      // partial ready
      flits(4'h0, 4'h0, 8'hE4);
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      chk("clr_state", int'(o_state), 0);
      chk("clr_total", int'(o_total_pkts), 0);
      chk("clr_start", int'(o_start_cycle), 0);
      flits(4'hF, 4'h5, 8'hE4);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick(2);
      chk("s2_total", int'(o_total_pkts), 4);
      port_is(0, 2);
      port_is(1, 0);
      port_is(2, 2);
      i_clear = 1'b1;
      i_start = 1'b1;
      tick();
      i_clear = 1'b0;
      chk("clr_prio_state", int'(o_state), 0);
      chk("clr_prio_total", int'(o_total_pkts), 0);
      flits(4'hF, 4'h7, 8'hE4);
      tick();
      i_start = 1'b0;
      tick(3);
      chk("s2b_state", int'(o_state), 2);
      chk("s2b_total", int'(o_total_pkts), 9);
      // misroute then timeout
      flits(4'h0, 4'h0, 8'hE4);
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      flits(4'h2, 4'h2, 8'hEC);
      tick(4);
      flits(4'h0, 4'h0, 8'hE4);
      chk("s3_mis", int'(o_misroute_cnt), 4);
      chk("s3_total", int'(o_total_pkts), 4);
      port_is(1, 4);
      tick(45);
      chk("s3_pre_tmo", int'(o_state), 1);
      tick();
      chk("s3_tmo_state", int'(o_state), 3);
      chk("s3_tmo_flag", int'(o_timeout), 1);
      chk("s3_elapsed", int'(o_elapsed), 50);
      // completion on the timeout edge
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      flits(4'h1, 4'h1, 8'hE4);
      tick(7);
      flits(4'h0, 4'h0, 8'hE4);
      tick(42);
      flits(4'h1, 4'h1, 8'hE4);
      tick();
      flits(4'h0, 4'h0, 8'hE4);
      chk("s4_state", int'(o_state), 2);
      chk("s4_timeout", int'(o_timeout), 0);
      chk("s4_total", int'(o_total_pkts), 8);
      chk("s4_elapsed", int'(o_elapsed), 50);
      // reset mid-run
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      flits(4'hF, 4'hF, 8'hE4);
      tick();
      chk("s5_total", int'(o_total_pkts), 4);
      rst = 1'b1;
      tick();
      chk("s5_rst_state", int'(o_state), 0);
      chk("s5_rst_total", int'(o_total_pkts), 0);
      port_is(0, 0);
      rst = 1'b0;
      flits(4'h0, 4'h0, 8'hE4);
      tick(3);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk("s5_restart", int'(o_start_cycle), 3);
      chk("s5_run", int'(o_state), 1);
      tick(3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
